mtsp_gprs_bank: RTL

- Parametrised successor of the per-primitive GPR access stage: one single-ported GPR bank shared by N_SRC source-read slots and N_WB write-back slots.
- Each cycle it selects one enabled slot by fixed priority and registers address, mask and data. It then performs the array access and returns read data two cycles after the request.
- Adds behaviour the previous generation lacked: post-reset zero-init sweep with READY, conflict detection and counting, per-read valid/slot tagging, and configurable lane count and width.

---
 rtl/mtsp_gprs_bank.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mtsp_gprs_bank.sv
// ---------------------------------------------------------------------------
// mtsp_gprs_bank
//   Single-ported GPR bank shared by N_SRC read slots and N_WB write-back
//   slots. One request per cycle is granted by fixed priority (lowest slot
//   index wins), registered in S0, and executed against the array in S1.
//   Read results appear two cycles after the request. After reset the
//   array is swept to zero; READY rises once the sweep is complete.
//
// Ports
//   CLK          clock
//   RST          synchronous active-high reset
//   nEN          per-slot request, active-low (bit i = slot i)
//   SRC_ADDR     read addresses, slot i at [i*AW +: AW]
//   WB_WMASK     write lane masks, 1 = lane not written
//   WB_ADDR      write addresses
//   WB_DATA      write data
//   READY        bank initialised and accepting requests
//   RDATA        read data
//   RVALID       RDATA carries a new read result this cycle
//   RSLOT        slot index that produced RDATA
//   CONFLICT     pulse: more than one slot requested in the same cycle
//   CONFLICT_CNT saturating count of conflict cycles
// ---------------------------------------------------------------------------
module mtsp_gprs_bank #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned N_WB   = 2,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned NS = N_SRC + N_WB,
    localparam int unsigned SW = $clog2(NS),
    localparam int unsigned DW = LANES * LANE_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NS-1:0]           nEN,
    input  logic [N_SRC*AW-1:0]     SRC_ADDR,
    input  logic [N_WB*LANES-1:0]   WB_WMASK,
    input  logic [N_WB*AW-1:0]      WB_ADDR,
    input  logic [N_WB*DW-1:0]      WB_DATA,
    output logic                    READY,
    output logic [DW-1:0]           RDATA,
    output logic                    RVALID,
    output logic [SW-1:0]           RSLOT,
    output logic                    CONFLICT,
    output logic [15:0]             CONFLICT_CNT
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;

    logic [DW-1:0] r_mem [DEPTH];

    // S0 stage registers
    logic             r_s0_vld;
    logic             r_s0_wr;
    logic [AW-1:0]    r_s0_addr;
    logic [SW-1:0]    r_s0_slot;
    logic [LANES-1:0] r_s0_wmask;
    logic [DW-1:0]    r_s0_wdata;

    // output registers
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [SW-1:0] r_rslot;
    logic          r_conflict;
    logic [15:0]   r_cnt;

    // grant
    logic             w_gnt_vld;
    logic             w_gnt_wr;
    logic [AW-1:0]    w_gnt_addr;
    logic [SW-1:0]    w_gnt_slot;
    logic [LANES-1:0] w_gnt_wmask;
    logic [DW-1:0]    w_gnt_wdata;
    logic [NS-1:0]    w_req;
    logic             w_multi;
    logic             w_run;

    // array write port
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [DW-1:0]    w_wdata;
    logic [LANES-1:0] w_wlane;

    assign w_run   = (r_state == ST_RUN);
    assign w_req   = ~nEN;
    // clearing the lowest set bit leaves something only if 2+ bits were set
    assign w_multi = ((w_req & (w_req - NS'(1))) != '0);

    // Read slots are scanned first, so any read beats any write-back.
    always_comb begin
        w_gnt_vld   = 1'b0;
        w_gnt_wr    = 1'b0;
        w_gnt_addr  = '0;
        w_gnt_slot  = '0;
        w_gnt_wmask = '0;
        w_gnt_wdata = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!w_gnt_vld && w_req[i]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_slot = SW'(i);
                w_gnt_addr = SRC_ADDR[i*AW +: AW];
            end
        end
        for (int unsigned j = 0; j < N_WB; j++) begin
            if (!w_gnt_vld && w_req[N_SRC+j]) begin
                w_gnt_vld   = 1'b1;
                w_gnt_wr    = 1'b1;
                w_gnt_slot  = SW'(N_SRC + j);
                w_gnt_addr  = WB_ADDR[j*AW +: AW];
                w_gnt_wmask = WB_WMASK[j*LANES +: LANES];
                w_gnt_wdata = WB_DATA[j*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_INIT: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // The single array port is shared between the zero sweep and S1 writes.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        w_wlane = '0;
        if (!RST) begin
            if (!w_run) begin
                w_we    = 1'b1;
                w_waddr = r_ptr;
                w_wlane = '1;
            end else if (r_s0_vld && r_s0_wr) begin
                w_we    = 1'b1;
                w_waddr = r_s0_addr;
                w_wdata = r_s0_wdata;
                w_wlane = ~r_s0_wmask;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (w_wlane[l]) r_mem[w_waddr][l*LANE_W +: LANE_W] <= w_wdata[l*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s0_vld   <= 1'b0;
            r_s0_wr    <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_slot  <= '0;
            r_s0_wmask <= '0;
            r_s0_wdata <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rslot    <= '0;
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_s0_vld   <= w_run && w_gnt_vld;
            r_s0_wr    <= w_gnt_wr;
            r_s0_addr  <= w_gnt_addr;
            r_s0_slot  <= w_gnt_slot;
            r_s0_wmask <= w_gnt_wmask;
            r_s0_wdata <= w_gnt_wdata;

            r_conflict <= w_run && w_multi;
            if (w_run && w_multi && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;

            r_rvalid <= r_s0_vld && !r_s0_wr;
            if (r_s0_vld && !r_s0_wr) begin
                r_rdata <= r_mem[r_s0_addr];
                r_rslot <= r_s0_slot;
            end
        end
    end

    assign READY        = w_run;
    assign RDATA        = r_rdata;
    assign RVALID       = r_rvalid;
    assign RSLOT        = r_rslot;
    assign CONFLICT     = r_conflict;
    assign CONFLICT_CNT = r_cnt;

endmodule
